barcode_reader: RTL and testbench
=================================

# barcode_reader

Serial barcode decoder for the follower digital core. It watches the asynchronous `BC` line from the optical barcode sensor and measures the low time of a start bit to learn the bit timing. It then decodes 8 self-clocked data bits, MSB first, and presents the station ID to the core with a valid flag that the core clears.

## Interface
- No parameters. The counter width is fixed at 22 bits, which supports bit periods up to 2^22−1 clocks.
- `clk` input 1: the single system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `BC` input 1: raw barcode serial line, asynchronous to `clk`, idles high.
- `clr_ID_vld` input 1: synchronous clear of `ID_vld`, pulsed by the digital core.
- `ID` output 8: last decoded station ID.
- `ID_vld` output 1: high when `ID` holds a valid, unconsumed station ID.

## Operation
- **Line format**
  - Each bit starts with a falling edge of `BC`.
  - The start bit is low for half a bit period and is always present.
  - Data bit '1' is low for clearly less than the start-bit low time (nominally ¼ period).
  - Data bit '0' is low for clearly more than the start-bit low time (nominally ¾ period).
  - 8 data bits follow the start bit, MSB first, then the line returns idle high.
- **Synchronizer:** `BC` passes through a 2-flop synchronizer, both flops reset to 1. A falling edge means the previous synchronized value is 1 and the current value is 0.
- **State machine**
  - IDLE: wait for a falling edge, then clear the duration counter and go to START.
  - START: increment the duration counter each clock while the synchronized line is low. On the rising edge, latch the count as `half_per` and go to WAIT_FALL. The counter saturates at all-ones and does not wrap.
  - WAIT_FALL: on a falling edge, clear the counter and go to SAMPLE.
  - SAMPLE: count up. When the count equals `half_per`, shift the synchronized `BC` into the ID shift register LSB (left shift) and increment the bit counter.
    - After the 8th bit, go to IDLE.
    - Otherwise go to WAIT_FALL.
- **Validity:** when the 8th bit is captured, if shifted value[7:6] == 2'b00, load `ID` with the shifted value and set `ID_vld`. Otherwise leave both `ID` and `ID_vld` unchanged.
- **Clearing:** `clr_ID_vld` clears `ID_vld` on the next edge. If set and clear occur in the same cycle, set wins.
- **Overwrite:** a new valid frame while `ID_vld` is already high overwrites `ID` and keeps `ID_vld` high.
- **No timeout:** an incomplete frame holds its state until the next falling edges or a reset.

## Timing
- Reset values:
  - `ID` = 8'h00, `ID_vld` = 0.
  - State = IDLE; bit counter, duration counter and `half_per` = 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts the frame immediately; the next falling edge after reset is treated as a start bit.
- Edge-detect latency is 2 clocks from a `BC` transition; all durations are measured on the synchronized line.
- Each data bit is sampled `half_per` clocks after its synchronized falling edge.
- `ID`/`ID_vld` update 1 clock after the 8th sample.
- With period P, a frame completes about 8.5·P clocks after the start-bit falling edge, e.g. about 8500 clocks for P = 1000.
- `ID_vld` falls 1 clock after `clr_ID_vld` is sampled high.

## Test plan
- Reset, then the `barcode_mimic` generator sends station_ID 0x36 with period 1000 → `ID_vld` = 1 and `ID` = 0x36 within 10000 clocks. `ID_vld` stays high until `clr_ID_vld` is pulsed, then reads 0 on the next cycle.
- After clearing, send 0x80 at period 1000 → `ID_vld` remains 0 for the whole frame and after it; `ID` keeps 0x36.
- Clear, then send 0x3A at period 1000 → `ID_vld` = 1 and `ID` = 0x3A.
- Send 0x15 at period 64, then 0x2C at period 4000 with no clear between → `ID` = 0x15 with `ID_vld` = 1, then `ID` = 0x2C with `ID_vld` still 1.
- Assert `rst_n` low during the 4th data bit → `ID` = 0 and `ID_vld` = 0 at once. A following full 0x36 frame decodes correctly.
- Pulse `clr_ID_vld` in the same cycle as the 8th-bit capture of a valid frame → `ID_vld` = 1 (set priority).

Source files
------------

// File: rtl/barcode_reader.sv
// Barcode serial decoder: learns bit timing from the start-bit low time, then
// samples 8 self-clocked data bits (MSB first) and posts a valid station ID.
module barcode_reader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [1:0] {IDLE, START, WAIT_FALL, SAMPLE} state_t;

  state_t      state_q, state_d;
  logic        bc_meta_q, bc_sync_q, bc_prev_q;
  logic [21:0] cnt_q, cnt_d;
  logic [21:0] half_per_q, half_per_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  id_q, id_d;
  logic        id_vld_q, id_vld_d;

  logic        fall;
  logic        set_vld;
  logic [7:0]  shifted;
  logic [21:0] cnt_inc;

  always_comb begin
    fall       = bc_prev_q & ~bc_sync_q;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 22'd1;
    shifted    = {shift_q[6:0], bc_sync_q};
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_per_d = half_per_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    id_d       = id_q;
    set_vld    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bc_sync_q) begin
          half_per_d = cnt_q;
          state_d    = WAIT_FALL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cnt_q == half_per_q) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = IDLE;
            // Only IDs with the two top bits clear are real stations.
            if (shifted[7:6] == 2'b00) begin
              id_d    = shifted;
              set_vld = 1'b1;
            end
          end else begin
            state_d = WAIT_FALL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    id_vld_d = set_vld | (id_vld_q & ~clr_ID_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bc_meta_q  <= 1'b1;
      bc_sync_q  <= 1'b1;
      bc_prev_q  <= 1'b1;
      cnt_q      <= '0;
      half_per_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      id_q       <= '0;
      id_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_meta_q  <= BC;
      bc_sync_q  <= bc_meta_q;
      bc_prev_q  <= bc_sync_q;
      cnt_q      <= cnt_d;
      half_per_q <= half_per_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      id_q       <= id_d;
      id_vld_q   <= id_vld_d;
    end
  end

  assign ID     = id_q;
  assign ID_vld = id_vld_q;

endmodule

// File: tb/tb_barcode_reader.sv
// Bench for barcode_reader: barcode line generator, expected-ID queue, and a
// monitor that checks every newly presented ID against the queue.
module tb_barcode_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_id;

  always #5 clk = ~clk;

  barcode_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_ID_vld = 1'b1;
    cycles(1);
    clr_ID_vld = 1'b0;
    chk("clr_vld", {31'd0, ID_vld}, 32'd0);
  endtask

  // Generates one frame; abort_bit >= 0 resets the DUT inside that data bit,
  // clr_last holds clr_ID_vld high across the final bit's sample point.
  task automatic send(input logic [7:0] id, input int per, input int abort_bit, input bit clr_last);
    int lo;
    if (abort_bit < 0 && id < 8'd64) begin
      exp_q.push_back(id);
      model_id = id;
    end
    BC = 1'b0; cycles(per / 2);
    BC = 1'b1; cycles(per / 2);
    for (int b = 7; b >= 0; b--) begin
      lo = id[b] ? per / 4 : 3 * per / 4;
      BC = 1'b0;
      if (7 - b == abort_bit) begin
        cycles(per / 8);
        rst_n = 1'b0;
        #1;
        chk("rst_id", {24'd0, ID}, 32'd0);
        chk("rst_vld", {31'd0, ID_vld}, 32'd0);
        model_id = 8'h00;
        BC = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(10);
        return;
      end
      if (clr_last && b == 0) begin
        cycles(per / 4);
        clr_ID_vld = 1'b1;
        cycles(lo - per / 4);
      end else begin
        cycles(lo);
      end
      BC = 1'b1;
      cycles(per - lo);
    end
    cycles(5);
    clr_ID_vld = 1'b0;
  endtask

  // Monitor: a rising ID_vld, or a new ID while valid, is one presented output.
  initial begin
    logic       prev_vld;
    logic [7:0] prev_id;
    logic [7:0] e;
    prev_vld = 1'b0;
    prev_id  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_vld = 1'b0;
        prev_id  = ID;
      end else begin
        if (ID_vld === 1'b1 && (!prev_vld || ID !== prev_id)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got ID %0h with ID_vld=1, expected no output", ID);
          end else begin
            e = exp_q.pop_front();
            chk("sb_id", {24'd0, ID}, {24'd0, e});
          end
        end
        prev_vld = ID_vld;
        prev_id  = ID;
      end
    end
  end

  initial begin
    logic [7:0] rid;
    int         rper;
    rst_n      = 1'b0;
    BC         = 1'b1;
    clr_ID_vld = 1'b0;
    model_id   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_id", {24'd0, ID}, 32'd0);
    chk("reset_vld", {31'd0, ID_vld}, 32'd0);
    rst_n = 1'b1;
    cycles(5);

    send(8'h36, 1000, -1, 1'b0);
    chk("t1_vld", {31'd0, ID_vld}, 32'd1);
    chk("t1_id", {24'd0, ID}, 32'h36);
    cycles(200);
    chk("t1_hold", {31'd0, ID_vld}, 32'd1);
    pulse_clr();

    send(8'h80, 1000, -1, 1'b0);
    cycles(50);
    chk("t2_vld", {31'd0, ID_vld}, 32'd0);
    chk("t2_id", {24'd0, ID}, 32'h36);

    pulse_clr();
    send(8'h3A, 1000, -1, 1'b0);
    chk("t3_vld", {31'd0, ID_vld}, 32'd1);
    chk("t3_id", {24'd0, ID}, 32'h3A);

    send(8'h15, 64, -1, 1'b0);
    chk("t4a_vld", {31'd0, ID_vld}, 32'd1);
    chk("t4a_id", {24'd0, ID}, 32'h15);
    send(8'h2C, 4000, -1, 1'b0);
    chk("t4b_vld", {31'd0, ID_vld}, 32'd1);
    chk("t4b_id", {24'd0, ID}, 32'h2C);

    send(8'h36, 200, 3, 1'b0);
    chk("t5_abort_vld", {31'd0, ID_vld}, 32'd0);
    chk("t5_abort_id", {24'd0, ID}, 32'd0);
    send(8'h36, 500, -1, 1'b0);
    chk("t5_vld", {31'd0, ID_vld}, 32'd1);
    chk("t5_id", {24'd0, ID}, 32'h36);

    pulse_clr();
    send(8'h2A, 100, -1, 1'b1);
    chk("t6_pending", exp_q.size(), 32'd0);
    chk("t6_vld_after", {31'd0, ID_vld}, 32'd0);
    chk("t6_id", {24'd0, ID}, 32'h2A);

    for (int i = 0; i < 8; i++) begin
      rid = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rid[7:6] = 2'b00;
      rper = 4 * $urandom_range(10, 50);
      send(rid, rper, -1, 1'b0);
      chk("rnd_vld", {31'd0, ID_vld}, (rid < 8'd64) ? 32'd1 : 32'd0);
      chk("rnd_id", {24'd0, ID}, {24'd0, model_id});
      pulse_clr();
      cycles($urandom_range(1, 30));
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
